// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit byte-slot scheduler.
// Optional watchdog is enabled by defining UART_TX_TIMEOUT_EN (see top).
package uart_tx_scheduler_pkg;

    // Scheduler state: IDLE presents the idle byte, SEND presents a latched byte
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Byte presented to the UART when nothing is granted (a no-op downstream)
    localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'h00;

    // Conventional requester slots
    localparam int REQ_MANUAL = 0;
    localparam int REQ_SCRIPT = 1;

    // Width of requester indices / grant_id, independent of NUM_REQ
    localparam int ID_W = 2;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM_REQ.
module uart_tx_scheduler_rr_arbiter
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any_valid
);

    // Scan offsets from furthest to nearest so the nearest asserted request wins
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NUM_REQ]) begin
                winner    = ID_W'((int'(ptr) + k) % NUM_REQ);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares the UART transmit byte slot between NUM_REQ producers using
// round-robin arbitration. New bytes load only on tx_done (frame boundary).
// Optional feature: define UART_TX_TIMEOUT_EN to add a SEND-state watchdog
// that drops a stalled byte and raises a sticky timeout_err.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int         NUM_REQ     = 2,
    parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hold,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [7:0]           tx_bits,
    input  logic                 tx_done,
    output logic                 busy,
    output logic [1:0]           grant_id,
    output logic [15:0]          sent_cnt,
    output logic                 timeout_err
);

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   winner;
    logic              any_valid;
    logic [7:0]        win_data;
    logic [NUM_REQ-1:0] win_onehot;
    logic [ID_W-1:0]   rr_next;

    uart_tx_scheduler_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .winner   (winner),
        .any_valid(any_valid)
    );

    // Winner's byte, its one-hot ack, and the pointer position after it
    always_comb begin
        win_data   = IDLE_BYTE;
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                win_data      = req_data[8*i +: 8];
                win_onehot[i] = 1'b1;
            end
        end
        rr_next = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
    end

`ifdef UART_TX_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] wd_cnt;
    logic        to_flag;
    assign timeout_err = to_flag;
`else
    assign timeout_err = 1'b0;
`endif

    // Frame-boundary scheduler: complete, count, then pick and latch the next byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_bits  <= IDLE_BYTE;
            req_ack  <= '0;
            busy     <= 1'b0;
            grant_id <= '0;
            sent_cnt <= '0;
            rr_ptr   <= '0;
`ifdef UART_TX_TIMEOUT_EN
            wd_cnt   <= '0;
            to_flag  <= 1'b0;
`endif
        end else begin
            req_ack <= '0;
            if (tx_done) begin
                if (state == SEND) begin
                    sent_cnt <= sent_cnt + 16'd1;
                end
                if (!hold && any_valid) begin
                    tx_bits  <= win_data;
                    grant_id <= winner;
                    busy     <= 1'b1;
                    state    <= SEND;
                    req_ack  <= win_onehot;
                    rr_ptr   <= rr_next;
                end else begin
                    tx_bits  <= IDLE_BYTE;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
`ifdef UART_TX_TIMEOUT_EN
                wd_cnt <= '0;
`endif
            end
`ifdef UART_TX_TIMEOUT_EN
            // Stalled frame: drop the byte without counting it
            else if (state == SEND) begin
                if (wd_cnt == TO_LAST) begin
                    to_flag <= 1'b1;
                    state   <= IDLE;
                    tx_bits <= IDLE_BYTE;
                    busy    <= 1'b0;
                    wd_cnt  <= '0;
                end else begin
                    wd_cnt <= wd_cnt + 16'd1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler (NUM_REQ=2, TIMEOUT_CYC=16).
// Honors UART_TX_TIMEOUT_EN for the watchdog scenario.
module tb_uart_tx_scheduler;

    localparam int NR = 2;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          hold = 1'b0;
    logic [NR-1:0] req_valid = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0] req_ack;
    logic [7:0]    tx_bits;
    logic          tx_done = 1'b0;
    logic          busy;
    logic [1:0]    grant_id;
    logic [15:0]   sent_cnt;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;

    uart_tx_scheduler #(
        .NUM_REQ    (NR),
        .IDLE_BYTE  (8'h00),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (hold),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ack    (req_ack),
        .tx_bits    (tx_bits),
        .tx_done    (tx_done),
        .busy       (busy),
        .grant_id   (grant_id),
        .sent_cnt   (sent_cnt),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_tx   = 8'h00;
    logic        m_busy = 1'b0;
    logic [1:0]  m_gid  = 2'd0;
    logic [15:0] m_cnt  = 16'd0;
    int          m_rr   = 0;
    logic [NR-1:0] m_ack = '0;
    logic        m_to   = 1'b0;
    int          m_wd   = 0;
    int          m_win;

    // First valid requester found walking from the pointer, or -1
    function automatic int pick(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    assign m_win = pick(req_valid, m_rr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tx <= 8'h00; m_busy <= 1'b0; m_gid <= 2'd0; m_cnt <= 16'd0;
            m_rr <= 0; m_ack <= '0; m_to <= 1'b0; m_wd <= 0;
        end else begin
            m_ack <= '0;
            if (tx_done) begin
                m_wd <= 0;
                if (m_busy) m_cnt <= m_cnt + 16'd1;
                if (!hold && m_win >= 0) begin
                    m_tx   <= req_data[8*m_win +: 8];
                    m_gid  <= 2'(m_win);
                    m_busy <= 1'b1;
                    m_ack  <= NR'(1) << m_win;
                    m_rr   <= (m_win + 1) % NR;
                end else begin
                    m_tx   <= 8'h00;
                    m_busy <= 1'b0;
                end
            end
`ifdef UART_TX_TIMEOUT_EN
            else if (m_busy) begin
                if (m_wd + 1 == TO) begin
                    m_to <= 1'b1; m_busy <= 1'b0; m_tx <= 8'h00; m_wd <= 0;
                end else begin
                    m_wd <= m_wd + 1;
                end
            end
`endif
        end
    end

    // Every-cycle comparison against the model, on the falling edge
    always @(negedge clk) begin
        check("cyc_tx_bits", 32'(tx_bits), 32'(m_tx));
        check("cyc_busy", 32'(busy), 32'(m_busy));
        check("cyc_sent_cnt", 32'(sent_cnt), 32'(m_cnt));
        check("cyc_req_ack", 32'(req_ack), 32'(m_ack));
        check("cyc_timeout_err", 32'(timeout_err), 32'(m_to));
        if (m_busy) check("cyc_grant_id", 32'(grant_id), 32'(m_gid));
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse();
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic txn(input string name, input logic [1:0] ack, input logic [7:0] tx,
                       input logic b, input logic [15:0] cnt);
        $display("txn %s: ack=%b tx_bits=%h busy=%0b grant_id=%0d sent_cnt=%0d",
                 name, req_ack, tx_bits, busy, grant_id, sent_cnt);
        check({name, "_ack"}, 32'(req_ack), 32'(ack));
        check({name, "_tx"}, 32'(tx_bits), 32'(tx));
        check({name, "_busy"}, 32'(busy), 32'(b));
        check({name, "_cnt"}, 32'(sent_cnt), 32'(cnt));
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        idle(3);
        txn("reset", 2'b00, 8'h00, 1'b0, 16'd0);
        check("reset_gid", 32'(grant_id), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Idle pulses: nothing requested
        for (int i = 0; i < 3; i++) begin
            pulse();
            txn("idle", 2'b00, 8'h00, 1'b0, 16'd0);
            idle(2);
        end

        // Single request
        req_data[7:0] = 8'h2A; req_valid = 2'b01;
        idle(1);
        pulse();
        txn("single_grant", 2'b01, 8'h2A, 1'b1, 16'd0);
        check("single_gid", 32'(grant_id), 32'd0);
        req_valid = 2'b00;
        idle(3);
        pulse();
        txn("single_done", 2'b00, 8'h00, 1'b0, 16'd1);

        // Contention from a fresh pointer
        do_reset();
        req_data = {8'h22, 8'h11}; req_valid = 2'b11;
        idle(1);
        pulse(); txn("cont1", 2'b01, 8'h11, 1'b1, 16'd0); idle(3);
        pulse(); txn("cont2", 2'b10, 8'h22, 1'b1, 16'd1); idle(3);
        pulse(); txn("cont3", 2'b01, 8'h11, 1'b1, 16'd2); idle(3);
        pulse(); txn("cont4", 2'b10, 8'h22, 1'b1, 16'd3);

        // Hold while sending 0x33
        req_data[7:0] = 8'h33; req_valid = 2'b01;
        idle(2);
        pulse(); txn("hold_grant", 2'b01, 8'h33, 1'b1, 16'd4);
        req_data[15:8] = 8'h44; req_valid = 2'b10; hold = 1'b1;
        idle(3);
        pulse(); txn("hold_block", 2'b00, 8'h00, 1'b0, 16'd5);
        hold = 1'b0;
        idle(3);
        pulse(); txn("hold_release", 2'b10, 8'h44, 1'b1, 16'd5);
        check("hold_gid", 32'(grant_id), 32'd1);

        // Withdrawn request before a pulse is never acked
        req_valid = 2'b01;
        idle(2);
        req_valid = 2'b00;
        idle(2);
        pulse(); txn("withdraw", 2'b00, 8'h00, 1'b0, 16'd6);

        // Stalled frame
        req_data[7:0] = 8'h55; req_valid = 2'b01;
        idle(1);
        pulse(); txn("stall_grant", 2'b01, 8'h55, 1'b1, 16'd6);
        req_valid = 2'b00;
        idle(TO + 4);
`ifdef UART_TX_TIMEOUT_EN
        txn("timeout", 2'b00, 8'h00, 1'b0, 16'd6);
        check("timeout_err", 32'(timeout_err), 32'd1);
`else
        txn("no_timeout", 2'b00, 8'h55, 1'b1, 16'd6);
        check("timeout_err", 32'(timeout_err), 32'd0);
        pulse(); txn("stall_done", 2'b00, 8'h00, 1'b0, 16'd7);
`endif

        // Asynchronous reset mid-SEND, observed before any clock edge
        req_data[7:0] = 8'h66; req_valid = 2'b01;
        idle(1);
        pulse(); txn("pre_reset", 2'b01, 8'h66, 1'b1, 16'(m_cnt));
        req_valid = 2'b00;
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        txn("async_reset", 2'b00, 8'h00, 1'b0, 16'd0);
        check("async_reset_to", 32'(timeout_err), 32'd0);
        idle(1);
        rst_n = 1'b1;

        // Pointer restarts at 0, but only requester 1 is valid
        req_data[15:8] = 8'h77; req_valid = 2'b10;
        idle(1);
        pulse(); txn("post_reset", 2'b10, 8'h77, 1'b1, 16'd0);
        req_valid = 2'b00;
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single UART transmit byte slot (`io_dataIn_bits` / `io_dataIn_ready`) between several byte producers, e.g. manual operation sender and script executor.
- Round-robin arbitration; byte boundaries are paced by the UART's one-cycle `ready` pulse.
- Presents an idle byte when no request is pending.
- Sits between the producers and the UART module, in the UART 16x clock domain.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- IDLE_BYTE, 8'h00, byte presented when nothing is granted (no-op to the game).
- TIMEOUT_CYC, 4096, max clk cycles between `tx_done` pulses while sending (optional feature only).

Ports:
- clk  in  1  UART 16x clock (same as UART module).
- rst_n  in  1  asynchronous, active-low reset.
- hold  in  1  suspend new grants (driven by script_mode while a script loads).
- req_valid  in  NUM_REQ  per-requester byte available.
- req_data  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
- req_ack  out  NUM_REQ  one-cycle pulse: byte of requester i accepted.
- tx_bits  out  8  to UART io_dataIn_bits.
- tx_done  in  1  from UART io_dataIn_ready; one-cycle pulse per finished frame.
- busy  out  1  a granted (non-idle) byte is in flight.
- grant_id  out  2  requester owning the in-flight byte; valid only while busy.
- sent_cnt  out  16  count of completed non-idle bytes.
- timeout_err  out  1  sticky timeout flag (tied 0 when feature absent).

Behaviour:
- Reset values: tx_bits=IDLE_BYTE, req_ack=0, busy=0, grant_id=0, sent_cnt=0, timeout_err=0, rr pointer=0, state=IDLE.
- States:
  - IDLE: tx_bits=IDLE_BYTE.
  - SEND: tx_bits=latched byte.
- Loading happens only on a cycle where tx_done=1; this is a frame boundary, so the UART never sees a mid-frame change.
- On tx_done:
  - If state==SEND: the latched byte is complete; sent_cnt++ (wraps 16'hFFFF->0).
  - Then select the next byte: if hold=0 and any req_valid, choose the winner by round-robin starting at the rr pointer.
    - Latch req_data[winner] into tx_bits, grant_id=winner, busy=1, state=SEND.
    - req_ack[winner]=1 for that same cycle only.
    - rr pointer = winner+1 mod NUM_REQ.
  - Otherwise tx_bits=IDLE_BYTE, busy=0, state=IDLE.
- Latency: a request asserted before a tx_done pulse is acked on that pulse and completes on the next pulse.
- Without tx_done, all state holds; req_valid changes have no effect.
- Requesters must hold req_valid/req_data stable until req_ack; after ack they may drop or present the next byte.
- Dropping req_valid before ack withdraws the request; no error is raised.
- hold asserted while in SEND: the in-flight byte finishes and is counted; no new load follows.
- Simultaneous requests: exactly one ack per tx_done, never two.
- Single requester continuously valid: back-to-back bytes, one per frame.
- rst_n asserted mid-frame: all outputs return to reset values immediately; the in-flight byte is lost and no ack is reissued.
- grant_id width is fixed at 2; upper bits are zero when NUM_REQ<=2.

Optional Feature:
- Macro: UART_TX_TIMEOUT_EN.
- With macro:
  - A 16-bit watchdog counts clk cycles while state==SEND and clears on each tx_done.
  - Reaching TIMEOUT_CYC sets timeout_err (sticky until reset) and forces state=IDLE, tx_bits=IDLE_BYTE, busy=0.
  - sent_cnt is not incremented and the byte is dropped.
- Without macro: no watchdog logic; timeout_err tied 0.

Decomposition:
- Shared package holds:
  - state enum {IDLE, SEND}
  - IDLE_BYTE default constant
  - requester index constants REQ_MANUAL=0, REQ_SCRIPT=1
- Natural sub-module: rr_arbiter, a combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: winner index, any_valid.
  - Used for the winner selection described under Behaviour.

Test Plan:
- Reset then idle: no req_valid, 3 tx_done pulses -> tx_bits stays 8'h00, busy=0, sent_cnt=0, no acks.
- Single request: req_valid[0]=1, data 8'h2A, tx_done -> req_ack[0] pulses, tx_bits=8'h2A, grant_id=0. Next tx_done with req dropped -> sent_cnt=1, tx_bits=8'h00.
- Contention: both valid (0x11 on req 0, 0x22 on req 1, held), 4 tx_done pulses -> tx_bits sequence 0x11, 0x22, 0x11, 0x22; acks alternate; sent_cnt=3 after the 4th pulse.
- Hold: during SEND of 0x33 assert hold with req 1 valid -> the next tx_done completes 0x33 (sent_cnt+1) and tx_bits=IDLE, no ack. Release hold -> next tx_done acks req 1.
- Async reset mid-SEND: drop rst_n between pulses -> tx_bits=8'h00, busy=0, sent_cnt=0 immediately, without a clk edge.
- Timeout (UART_TX_TIMEOUT_EN, TIMEOUT_CYC=16): grant a byte, then withhold tx_done for 16 cycles -> timeout_err=1, busy=0, tx_bits=8'h00, sent_cnt unchanged.
